// File: rtl/bridge_req_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ requester buses onto one downstream
// request/read-data port, one transfer at a time, with a read-wait timeout.
module bridge_req_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                            i_clk_ahb,
  input  logic                            i_rst_ahb,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  input  logic [NUM_REQ-1:0]              i_req_rd0_wr1,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   i_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_wr_data,
  output logic [NUM_REQ-1:0]              o_req_ready,
  output logic [NUM_REQ-1:0]              o_req_rd_valid,
  output logic [NUM_REQ-1:0]              o_req_err,
  output logic [DATA_WIDTH-1:0]           o_req_rd_data,
  output logic                            o_valid,
  output logic                            o_rd0_wr1,
  output logic [ADDR_WIDTH-1:0]           o_addr,
  output logic [DATA_WIDTH-1:0]           o_wr_data,
  input  logic                            i_ready,
  input  logic                            i_rd_valid,
  input  logic [DATA_WIDTH-1:0]           i_rd_data
);

  localparam int unsigned IDX_W = (NUM_REQ > 2) ? 2 : 1;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  logic              rr_found;
  logic [IDX_W-1:0]  rr_idx;
  logic [IDX_W-1:0]  rr_cand;

  logic              ready_c;
  logic              rd_valid_c;
  logic              err_c;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      addr_arr[i]  = i_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_arr[i] = i_req_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // First valid requester at or after the priority pointer, wrapping.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      rr_cand = IDX_W'((32'(ptr_q) + k) % NUM_REQ);
      if (!rr_found && i_req_valid[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

  always_ff @(posedge i_clk_ahb or posedge i_rst_ahb) begin
    if (i_rst_ahb) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    o_valid       = 1'b0;
    o_rd0_wr1     = 1'b0;
    o_addr        = '0;
    o_wr_data     = '0;
    o_req_rd_data = '0;
    ready_c       = 1'b0;
    rd_valid_c    = 1'b0;
    err_c         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rr_found) begin
          gnt_d   = rr_idx;
          ptr_d   = (rr_idx == IDX_LAST) ? '0 : rr_idx + IDX_W'(1);
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        o_valid   = i_req_valid[gnt_q];
        o_rd0_wr1 = i_req_rd0_wr1[gnt_q];
        o_addr    = addr_arr[gnt_q];
        o_wr_data = wdata_arr[gnt_q];
        if (!i_req_valid[gnt_q]) begin
          state_d = ST_IDLE;
        end else if (i_ready) begin
          ready_c = 1'b1;
          if (i_req_rd0_wr1[gnt_q]) begin
            state_d = ST_IDLE;
          end else if (i_rd_valid) begin
            rd_valid_c    = 1'b1;
            o_req_rd_data = i_rd_data;
            state_d       = ST_IDLE;
          end else begin
            cnt_d   = '0;
            state_d = ST_WAIT_RD;
          end
        end
      end

      ST_WAIT_RD: begin
        // Returned data beats the timeout when both land in the same cycle.
        if (i_rd_valid) begin
          rd_valid_c    = 1'b1;
          o_req_rd_data = i_rd_data;
          state_d       = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_c   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign o_req_ready    = ready_c    ? (NUM_REQ'(1) << gnt_q) : '0;
  assign o_req_rd_valid = rd_valid_c ? (NUM_REQ'(1) << gnt_q) : '0;
  assign o_req_err      = err_c      ? (NUM_REQ'(1) << gnt_q) : '0;

endmodule
